// File: rtl/cal_step_pulser_if.sv
// Button/step signal bundle between the board button inputs and cal_step_pulser.
// master drives the raw buttons and setting gate; slave returns step pulses and status.
interface cal_step_pulser_if #(
   parameter int N_CH = 2
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic            gate;
   logic [N_CH-1:0] btn_in;
   logic [N_CH-1:0] step_out;
   logic [CH_W-1:0] active_ch;
   logic            repeating;

   modport master (output gate, btn_in, input step_out, active_ch, repeating);
   modport slave  (input gate, btn_in, output step_out, active_ch, repeating);
endinterface

// File: rtl/cal_step_pulser.sv
// N-channel button-to-step-pulse generator: sync, debounce, multi-press lockout.
// Define CAL_STEP_AUTO_REPEAT_EN to build the hold-to-auto-repeat path.
module cal_step_pulser #(
   parameter int N_CH         = 2,
   parameter int DEBOUNCE_CYC = 16,
   parameter int HOLD_CYC     = 50000000,
   parameter int REPEAT_CYC   = 10000000
) (
   input logic               clock,
   input logic               reset,
   cal_step_pulser_if.slave  bus
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

`ifdef CAL_STEP_AUTO_REPEAT_EN
   localparam int HOLD_W = $clog2(HOLD_CYC);
   localparam int REP_W  = $clog2(REPEAT_CYC);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} state_t;
`else
   typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;
`endif

   logic [N_CH-1:0] sync1, sync2, db;
   logic [DB_W-1:0] db_cnt [N_CH];

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         for (int unsigned i = 0; i < N_CH; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= bus.btn_in;
         sync2 <= sync1;
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
               db[i]     <= ~db[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   state_t          state;
   logic [N_CH-1:0] step;
   logic [CH_W-1:0] act;
   logic [N_CH-1:0] c_mask;
   logic [CH_W-1:0] db_idx;
   logic            db_one;
   logic            abort;

   always_comb begin
      c_mask      = '0;
      c_mask[act] = 1'b1;
      db_idx      = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (db[i]) db_idx = CH_W'(i);
      end
      db_one = (db != '0) && ((db & (db - 1'b1)) == '0);
      abort  = !bus.gate || ((db & ~c_mask) != '0);
   end

`ifdef CAL_STEP_AUTO_REPEAT_EN
   logic [HOLD_W-1:0] hold_cnt;
   logic [REP_W-1:0]  rep_cnt;
   logic              rep;
`endif

   // Exit order while holding: gate/multi-press abort, then release, then expiry.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         step     <= '0;
         act      <= '0;
`ifdef CAL_STEP_AUTO_REPEAT_EN
         hold_cnt <= '0;
         rep_cnt  <= '0;
         rep      <= 1'b0;
`endif
      end else begin
         step <= '0;
         case (state)
            IDLE: begin
               if (db != '0) begin
                  if (bus.gate && db_one) begin
                     step     <= db;
                     act      <= db_idx;
`ifdef CAL_STEP_AUTO_REPEAT_EN
                     hold_cnt <= '0;
`endif
                     state    <= HOLD;
                  end else begin
                     act   <= '0;
                     state <= WAIT_REL;
                  end
               end
            end
            HOLD: begin
               if (abort) begin
                  act   <= '0;
                  state <= WAIT_REL;
               end else if (!db[act]) begin
                  act   <= '0;
                  state <= IDLE;
               end
`ifdef CAL_STEP_AUTO_REPEAT_EN
               else if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                  step     <= c_mask;
                  hold_cnt <= '0;
                  rep_cnt  <= '0;
                  rep      <= 1'b1;
                  state    <= REPEAT;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
`endif
            end
`ifdef CAL_STEP_AUTO_REPEAT_EN
            REPEAT: begin
               if (abort) begin
                  act   <= '0;
                  rep   <= 1'b0;
                  state <= WAIT_REL;
               end else if (!db[act]) begin
                  act   <= '0;
                  rep   <= 1'b0;
                  state <= IDLE;
               end else if (rep_cnt == REP_W'(REPEAT_CYC - 1)) begin
                  step    <= c_mask;
                  rep_cnt <= '0;
               end else begin
                  rep_cnt <= rep_cnt + 1'b1;
               end
            end
`endif
            WAIT_REL: begin
               if (db == '0) state <= IDLE;
            end
            default: begin
               act   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.step_out  = step;
   assign bus.active_ch = act;
`ifdef CAL_STEP_AUTO_REPEAT_EN
   assign bus.repeating = rep;
`else
   assign bus.repeating = 1'b0;
`endif
endmodule
